// File: rtl/mips_mem_pkg.sv
// Shared types for the simple_mips unified-memory port arbiter.
package mips_mem_pkg;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_WAIT = 2'd2
    } arb_state_e;

    localparam int STREAK_W = 4;

    // Next value of the DM streak counter, saturating at the configured limit.
    function automatic logic [STREAK_W-1:0] streak_next(
        input logic [STREAK_W-1:0] cur,
        input logic [STREAK_W-1:0] limit
    );
        return (cur >= limit) ? limit : cur + 1'b1;
    endfunction

endpackage

// File: rtl/mem_arb_perf.sv
// Grant and stall counters for the memory port arbiter.
// Only instantiated when MEMARB_PERF_EN is defined.
module mem_arb_perf (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic        if_gnt,
    input  logic        dm_req,
    input  logic        dm_gnt,
    output logic [31:0] perf_if_cnt,
    output logic [31:0] perf_dm_cnt,
    output logic [31:0] perf_stall_cnt
);

    logic stall;

    // A cycle is a stall when any requester is waiting without being granted.
    always_comb begin
        stall = (if_req && !if_gnt) || (dm_req && !dm_gnt);
    end

    // Free-running counters; they wrap naturally at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_if_cnt    <= '0;
            perf_dm_cnt    <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (if_gnt) perf_if_cnt    <= perf_if_cnt + 32'd1;
            if (dm_gnt) perf_dm_cnt    <= perf_dm_cnt + 32'd1;
            if (stall)  perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified instruction/data memory of simple_mips
// between the fetch stage (IF) and the load/store stage (DM). One
// transaction is in flight at a time: IDLE -> REQ -> WAIT -> IDLE.
// DM has priority; after MAX_DM_STREAK consecutive DM wins with a fetch
// pending, the fetch is served.
// Optional: define MEMARB_PERF_EN to add grant/stall performance counters.
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MAX_DM_STREAK = 4
) (
    input  logic                clk,
    input  logic                reset,
    // fetch port
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    // load/store port
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [DATA_W/8-1:0] dm_be,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    output logic                dm_gnt,
    output logic                dm_rvalid,
    output logic [DATA_W-1:0]   dm_rdata,
    // memory port
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
`ifdef MEMARB_PERF_EN
    ,
    output logic [31:0]         perf_if_cnt,
    output logic [31:0]         perf_dm_cnt,
    output logic [31:0]         perf_stall_cnt
`endif
);

    localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(MAX_DM_STREAK);

    arb_state_e           state;
    owner_e               owner;
    logic [STREAK_W-1:0]  streak;
    logic                 dm_wins;

    // DM wins unless a fetch is pending and DM has used up its streak.
    always_comb begin
        dm_wins = dm_req && !(if_req && (streak == STREAK_LIMIT));
    end

    // Arbiter FSM: latches the winner's fields into the memory-port registers.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent behaviour.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ARB_IDLE;
            owner     <= OWN_IF;
            streak    <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (dm_wins) begin
                        owner     <= OWN_DM;
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                        mem_be    <= dm_be;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        streak    <= if_req ? streak_next(streak, STREAK_LIMIT) : '0;
                        state     <= ARB_REQ;
                    end else if (if_req) begin
                        owner     <= OWN_IF;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_be    <= '1;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        streak    <= '0;
                        state     <= ARB_REQ;
                    end else begin
                        // No fetch pending: the streak no longer means anything.
                        streak    <= '0;
                    end
                end
                ARB_REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    if (mem_rvalid) state <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // Route the memory handshake to the current owner in the same cycle.
    // NOTE: every output gets a default first so no path infers a latch.
    always_comb begin
        if_gnt    = 1'b0;
        dm_gnt    = 1'b0;
        if_rvalid = 1'b0;
        dm_rvalid = 1'b0;
        if_rdata  = '0;
        dm_rdata  = '0;
        if (state == ARB_REQ && mem_gnt) begin
            if (owner == OWN_DM) dm_gnt = 1'b1;
            else                 if_gnt = 1'b1;
        end
        if (state == ARB_WAIT && mem_rvalid) begin
            if (owner == OWN_DM) begin
                dm_rvalid = 1'b1;
                dm_rdata  = mem_rdata;
            end else begin
                if_rvalid = 1'b1;
                if_rdata  = mem_rdata;
            end
        end
    end

`ifdef MEMARB_PERF_EN
    mem_arb_perf u_perf (
        .clk            (clk),
        .reset          (reset),
        .if_req         (if_req),
        .if_gnt         (if_gnt),
        .dm_req         (dm_req),
        .dm_gnt         (dm_gnt),
        .perf_if_cnt    (perf_if_cnt),
        .perf_dm_cnt    (perf_dm_cnt),
        .perf_stall_cnt (perf_stall_cnt)
    );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a transaction
// scoreboard; built with MAX_DM_STREAK=2 so the fairness pattern is short.
// Also checks the counters when MEMARB_PERF_EN is defined.
module tb_mem_port_arbiter;

    typedef struct {
        logic        is_dm;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, dm_req, dm_we, mem_gnt, mem_rvalid;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [3:0]  dm_be;
    logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid;
    logic [31:0] if_rdata, dm_rdata;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
`ifdef MEMARB_PERF_EN
    logic [31:0] perf_if_cnt, perf_dm_cnt, perf_stall_cnt;
`endif

    int   checks = 0;
    int   passes = 0;
    txn_t exp_q[$];

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DM_STREAK(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_be      (dm_be),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_gnt     (dm_gnt),
        .dm_rvalid  (dm_rvalid),
        .dm_rdata   (dm_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
`ifdef MEMARB_PERF_EN
        ,
        .perf_if_cnt    (perf_if_cnt),
        .perf_dm_cnt    (perf_dm_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // All outputs must be zero (reset state / nothing in flight).
    task automatic check_quiet(input string tag);
        check({tag, "_mem_req"}, mem_req, 0);
        check({tag, "_gnts"}, {if_gnt, dm_gnt}, 0);
        check({tag, "_rvalids"}, {if_rvalid, dm_rvalid}, 0);
        check({tag, "_rdatas"}, if_rdata | dm_rdata, 0);
    endtask

    // Memory responder: waits for mem_req, compares against the scoreboard,
    // grants after 'delay' cycles, responds one cycle later.
    task automatic serve(input int delay, input bit drop_if, input bit drop_dm);
        txn_t t;
        int   waited = 0;
        @(negedge clk);
        while (!mem_req && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        #1;
        check("mem_req_seen", mem_req, 1);
        if (exp_q.size() == 0) begin
            $display("FAIL sb_underflow: observed empty scoreboard expected an entry");
            $fatal(1, "scoreboard underflow");
        end
        t = exp_q.pop_front();
        for (int d = 0; d <= delay; d++) begin
            check("mem_req_hold", mem_req, 1);
            check("mem_we", mem_we, t.we);
            check("mem_be", mem_be, t.be);
            check("mem_addr", mem_addr, t.addr);
            check("mem_wdata", mem_wdata, t.wdata);
            if (d < delay) begin
                check("early_gnt", {if_gnt, dm_gnt}, 0);
                @(negedge clk);
                #1;
            end
        end
        mem_gnt = 1'b1;
        #1;
        check("if_gnt", if_gnt, !t.is_dm);
        check("dm_gnt", dm_gnt, t.is_dm);
        @(negedge clk);
        mem_gnt = 1'b0;
        if (drop_if) if_req = 1'b0;
        if (drop_dm) dm_req = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = t.rdata;
        #1;
        check("gnt_after_rvalid", {if_gnt, dm_gnt}, 0);
        check("if_rvalid", if_rvalid, !t.is_dm);
        check("dm_rvalid", dm_rvalid, t.is_dm);
        check("if_rdata", if_rdata, t.is_dm ? 32'h0 : t.rdata);
        check("dm_rdata", dm_rdata, t.is_dm ? t.rdata : 32'h0);
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
    endtask

    function automatic txn_t if_txn(input logic [31:0] addr, input logic [31:0] rdata);
        txn_t t;
        t.is_dm = 1'b0; t.we = 1'b0; t.be = 4'hF; t.addr = addr; t.wdata = '0; t.rdata = rdata;
        return t;
    endfunction

    function automatic txn_t dm_txn(input logic we, input logic [3:0] be, input logic [31:0] addr,
                                    input logic [31:0] wdata, input logic [31:0] rdata);
        txn_t t;
        t.is_dm = 1'b1; t.we = we; t.be = be; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
        return t;
    endfunction

    initial begin
        reset = 1'b1;
        if_req = 0; dm_req = 0; dm_we = 0; mem_gnt = 0; mem_rvalid = 0;
        if_addr = 0; dm_addr = 0; dm_wdata = 0; mem_rdata = 0; dm_be = 0;
        repeat (2) @(negedge clk);
        #1;
        check_quiet("reset");
        check("reset_mem_be", mem_be, 0);
        check("reset_mem_addr", mem_addr, 0);
        reset = 1'b0;

        // Store with mem_gnt held off for 5 cycles, straight out of reset.
        @(negedge clk);
        dm_req = 1; dm_we = 1; dm_be = 4'b0011; dm_addr = 32'h1001_0004; dm_wdata = 32'hDEAD_BEEF;
        exp_q.push_back(dm_txn(1'b1, 4'b0011, 32'h1001_0004, 32'hDEAD_BEEF, 32'h0000_0000));
        serve(5, 1'b0, 1'b1);
        dm_we = 0; dm_be = 4'hF; dm_wdata = 0;
        #1;
        check_quiet("after_store");
`ifdef MEMARB_PERF_EN
        check("perf_stall", perf_stall_cnt, 6);
        check("perf_dm", perf_dm_cnt, 1);
        check("perf_if", perf_if_cnt, 0);
`endif

        // Single fetch, immediate grant.
        if_req = 1; if_addr = 32'h0040_0000;
        exp_q.push_back(if_txn(32'h0040_0000, 32'h2008_0005));
        serve(0, 1'b1, 1'b0);

        // Simultaneous fetch and load: DM first, then IF.
        if_req = 1; if_addr = 32'h0040_0004;
        dm_req = 1; dm_addr = 32'h1001_0000;
        exp_q.push_back(dm_txn(1'b0, 4'hF, 32'h1001_0000, 32'h0, 32'h1111_2222));
        exp_q.push_back(if_txn(32'h0040_0004, 32'h3333_4444));
        serve(0, 1'b0, 1'b1);
        serve(1, 1'b1, 1'b0);
        repeat (3) begin
            @(negedge clk);
            #1;
            check_quiet("after_both");
        end

        // Both held continuously with MAX_DM_STREAK=2: DM,DM,IF,DM,DM,IF.
        if_req = 1; if_addr = 32'h0040_0008;
        dm_req = 1; dm_addr = 32'h1001_0008;
        for (int i = 0; i < 6; i++) begin
            if (i % 3 == 2) exp_q.push_back(if_txn(32'h0040_0008, 32'hA000_0000 + i));
            else            exp_q.push_back(dm_txn(1'b0, 4'hF, 32'h1001_0008, 32'h0, 32'hB000_0000 + i));
        end
        for (int i = 0; i < 6; i++) serve(0, i == 5, i == 5);
        check("streak_sb_drained", exp_q.size(), 0);
        @(negedge clk);
        #1;
        check_quiet("after_streak");

        // Reset asserted mid-cycle while in WAIT abandons the fetch.
        if_req = 1; if_addr = 32'h0040_000C;
        @(negedge clk);
        #1;
        check("pre_reset_req", mem_req, 1);
        mem_gnt = 1;
        @(negedge clk);
        mem_gnt = 0; if_req = 0;
        #2;
        reset = 1'b1;
        #1;
        check_quiet("async_reset");
        check("async_reset_addr", mem_addr, 0);
        @(negedge clk);
        reset = 1'b0;
        mem_rvalid = 1; mem_rdata = 32'hCAFE_F00D;
        #1;
        check_quiet("late_rvalid");
        @(negedge clk);
        mem_rvalid = 0; mem_rdata = 0;
        #1;
        check_quiet("post_reset_idle");

        // Arbiter is usable again after the abandoned transaction.
        if_req = 1; if_addr = 32'h0040_0010;
        exp_q.push_back(if_txn(32'h0040_0010, 32'h0C0F_FEE0));
        serve(0, 1'b1, 1'b0);
        check("final_sb_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
